// File: rtl/tm1640_frame_writer.sv
// TM1640 frame sequencer: one update strobe emits data cmd, address cmd, nine segment bytes, display cmd.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 0..7 with BLANK_CODE.
module tm1640_frame_writer #(
   parameter logic [7:0] BLANK_CODE = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        update,
   input  logic [35:0] digits,
   input  logic [8:0]  dp,
   input  logic [2:0]  bright,
   input  logic        disp_on,
   input  logic        tm_busy,
   output logic        tm_latch,
   output logic [7:0]  tm_byte,
   output logic        tm_end,
   output logic        busy,
   output logic        done
);
   localparam int unsigned NUM_DIGITS = 9;
   localparam int unsigned KW         = 4;
   localparam logic [KW-1:0] K_LAST   = KW'(11);

   typedef enum logic [2:0] {IDLE, LOAD, ACK, DRAIN, FIN} state_t;

   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic          pend_q, pend_d;
   logic [35:0]   snap_digits_q, snap_digits_d;
   logic [8:0]    snap_dp_q, snap_dp_d;
   logic [2:0]    snap_bright_q, snap_bright_d;
   logic          snap_on_q, snap_on_d;
   logic          tm_latch_q, tm_latch_d;
   logic [7:0]    tm_byte_q, tm_byte_d;
   logic          tm_end_q, tm_end_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          take_snap_c;

   logic [NUM_DIGITS-1:0] blank_c;
   logic [7:0]            cur_byte_c;
   logic                  cur_end_c;

   function automatic logic [6:0] seg_map(input logic [3:0] v);
      case (v)
         4'h0:    seg_map = 7'h3F;
         4'h1:    seg_map = 7'h06;
         4'h2:    seg_map = 7'h5B;
         4'h3:    seg_map = 7'h4F;
         4'h4:    seg_map = 7'h66;
         4'h5:    seg_map = 7'h6D;
         4'h6:    seg_map = 7'h7D;
         4'h7:    seg_map = 7'h07;
         4'h8:    seg_map = 7'h7F;
         4'h9:    seg_map = 7'h6F;
         4'hA:    seg_map = 7'h77;
         4'hB:    seg_map = 7'h7C;
         4'hC:    seg_map = 7'h39;
         4'hD:    seg_map = 7'h5E;
         4'hE:    seg_map = 7'h79;
         default: seg_map = 7'h71;
      endcase
   endfunction

   // Digit i is blanked while it and every lower-index digit are zero; digit 8 always shows.
`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      blank_c  = '0;
      for (int unsigned i = 0; i < NUM_DIGITS - 1; i++) begin
         zero_run   = zero_run & (snap_digits_q[4*i +: 4] == 4'h0);
         blank_c[i] = zero_run;
      end
   end
`else
   assign blank_c = '0;
`endif

   // Byte and end flag for the current stream index k.
   always_comb begin
      cur_byte_c = 8'h00;
      cur_end_c  = 1'b0;
      case (k_q)
         KW'(0): begin
            cur_byte_c = 8'h40;
            cur_end_c  = 1'b1;
         end
         KW'(1): cur_byte_c = 8'hC0;
         K_LAST: begin
            cur_byte_c = {4'b1000, snap_on_q, snap_bright_q};
            cur_end_c  = 1'b1;
         end
         default: begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
               if (k_q == KW'(i + 2)) begin
                  cur_byte_c    = blank_c[i] ? BLANK_CODE : {1'b0, seg_map(snap_digits_q[4*i +: 4])};
                  cur_byte_c[7] = cur_byte_c[7] | snap_dp_q[i];
               end
            end
            cur_end_c = (k_q == KW'(10));
         end
      endcase
   end

   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      pend_d        = pend_q;
      snap_digits_d = snap_digits_q;
      snap_dp_d     = snap_dp_q;
      snap_bright_d = snap_bright_q;
      snap_on_d     = snap_on_q;
      tm_latch_d    = tm_latch_q;
      tm_byte_d     = tm_byte_q;
      tm_end_d      = tm_end_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      take_snap_c   = 1'b0;
      if (state_q != IDLE) pend_d = pend_q | update;
      case (state_q)
         IDLE: begin
            if (update) begin
               take_snap_c = 1'b1;
               k_d         = '0;
               busy_d      = 1'b1;
               state_d     = LOAD;
            end
         end
         LOAD: begin
            tm_byte_d  = cur_byte_c;
            tm_end_d   = cur_end_c;
            tm_latch_d = 1'b1;
            state_d    = ACK;
         end
         ACK: begin
            if (tm_busy) begin
               tm_latch_d = 1'b0;
               state_d    = DRAIN;
            end
         end
         DRAIN: begin
            if (!tm_busy) begin
               if (k_q == K_LAST) begin
                  state_d = FIN;
                  done_d  = 1'b1;
                  busy_d  = pend_q | update;
               end else begin
                  k_d     = k_q + KW'(1);
                  state_d = LOAD;
               end
            end
         end
         FIN: begin
            pend_d = 1'b0;
            if (pend_q || update) begin
               take_snap_c = 1'b1;
               k_d         = '0;
               busy_d      = 1'b1;
               state_d     = LOAD;
            end else begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (take_snap_c) begin
         snap_digits_d = digits;
         snap_dp_d     = dp;
         snap_bright_d = bright;
         snap_on_d     = disp_on;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         k_q           <= '0;
         pend_q        <= 1'b0;
         snap_digits_q <= '0;
         snap_dp_q     <= '0;
         snap_bright_q <= '0;
         snap_on_q     <= 1'b0;
         tm_latch_q    <= 1'b0;
         tm_byte_q     <= 8'h00;
         tm_end_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         pend_q        <= pend_d;
         snap_digits_q <= snap_digits_d;
         snap_dp_q     <= snap_dp_d;
         snap_bright_q <= snap_bright_d;
         snap_on_q     <= snap_on_d;
         tm_latch_q    <= tm_latch_d;
         tm_byte_q     <= tm_byte_d;
         tm_end_q      <= tm_end_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign tm_latch = tm_latch_q;
   assign tm_byte  = tm_byte_q;
   assign tm_end   = tm_end_q;
   assign busy     = busy_q;
   assign done     = done_q;
endmodule

// File: tb/tb_tm1640_frame_writer.sv
// Bench for tm1640_frame_writer: byte-stream model, handshake driver model and per-cycle monitor.
module tb_tm1640_frame_writer;
   logic        clk = 1'b0;
   logic        rst, update, disp_on, tm_busy;
   logic [35:0] digits;
   logic [8:0]  dp;
   logic [2:0]  bright;
   logic        tm_latch, tm_end, busy, done;
   logic [7:0]  tm_byte;

   int errors = 0;
   int checks = 0;
   int ack_delay = 0;
   int busy_len = 5;
   int fr_cnt = 0;
   int done_cnt = 0;
   logic [8:0] exp_q[$];

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   tm1640_frame_writer dut (
      .clk(clk), .rst(rst), .update(update), .digits(digits), .dp(dp),
      .bright(bright), .disp_on(disp_on), .tm_busy(tm_busy),
      .tm_latch(tm_latch), .tm_byte(tm_byte), .tm_end(tm_end),
      .busy(busy), .done(done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] seg_of(input logic [3:0] v);
      case (v)
         4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
         4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
         4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
         4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
      endcase
   endfunction

   // Expected {end, byte} for stream index k of a frame built from the given inputs.
   function automatic logic [8:0] model_byte(input int k, input logic [35:0] dg, input logic [8:0] p,
                                             input logic [2:0] br, input logic on);
      logic [7:0] b;
      logic       lz;
      if (k == 0) return {1'b1, 8'h40};
      if (k == 1) return {1'b0, 8'hC0};
      if (k == 11) return {1'b1, 4'h8, on, br};
      lz = 1'b1;
      for (int j = 0; j <= k - 2; j++) if (dg[4*j +: 4] != 4'h0) lz = 1'b0;
      if (BLANK_EN && lz && (k - 2) < 8) b = 8'h00;
      else b = seg_of(dg[4*(k-2) +: 4]);
      b = b | {p[k-2], 7'h00};
      return {(k == 10), b};
   endfunction

   task automatic push_frame();
      for (int k = 0; k < 12; k++) exp_q.push_back(model_byte(k, digits, dp, bright, disp_on));
   endtask

   task automatic chk_reset();
      chk("rst_tm_latch", 32'(tm_latch), 32'd0);
      chk("rst_tm_byte", 32'(tm_byte), 32'h00);
      chk("rst_tm_end", 32'(tm_end), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
   endtask

   task automatic pulse_update();
      @(negedge clk); update = 1'b1;
      @(negedge clk); update = 1'b0;
   endtask

   // Push the expected frame and strobe update; optionally pin the start latency.
   task automatic start_frame(input bit check_latency);
      @(negedge clk);
      push_frame();
      update = 1'b1;
      if (check_latency) begin
         @(posedge clk); #1;
         chk("start_busy", 32'(busy), 32'd1);
         chk("start_latch_low", 32'(tm_latch), 32'd0);
      end
      @(negedge clk); update = 1'b0;
      if (check_latency) begin
         @(posedge clk); #1;
         chk("first_latch", 32'(tm_latch), 32'd1);
         chk("first_byte", 32'(tm_byte), 32'h40);
      end
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (!(exp_q.size() == 0 && busy === 1'b0 && tm_busy === 1'b0) && c < 5000) begin
         @(negedge clk);
         c++;
      end
      chk("idle_within_budget", 32'(c < 5000), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_fr(input int n);
      int c;
      c = 0;
      while (!(fr_cnt == n && tm_latch === 1'b1) && c < 2000) begin
         @(negedge clk);
         c++;
      end
      chk("byte_reached_within_budget", 32'(c < 2000), 32'd1);
   endtask

   // Driver model: acknowledge a latch after ack_delay cycles, stay busy for busy_len cycles.
   initial begin : driver
      tm_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tm_latch === 1'b1 && rst === 1'b1) begin
            repeat (ack_delay) @(negedge clk);
            tm_busy = 1'b1;
            repeat (busy_len) @(negedge clk);
            tm_busy = 1'b0;
         end
      end
   end

   // Compare process: every cycle out of reset, checks bytes, hold, busy and done against the model.
   initial begin : monitor
      logic       prev_latch, inflight, acked, held_end;
      logic [7:0] held_byte;
      logic [8:0] e;
      prev_latch = 1'b0; inflight = 1'b0; acked = 1'b0; held_end = 1'b0; held_byte = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (rst !== 1'b1) begin
            prev_latch = 1'b0; inflight = 1'b0; acked = 1'b0; fr_cnt = 0;
            continue;
         end
         if (inflight) begin
            chk("hold_byte", 32'(tm_byte), 32'(held_byte));
            chk("hold_end", 32'(tm_end), 32'(held_end));
            if (tm_busy) acked = 1'b1;
            else if (acked) inflight = 1'b0;
            else chk("latch_until_ack", 32'(tm_latch), 32'd1);
         end
         if (tm_latch && !prev_latch) begin
            chk("latch_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk($sformatf("byte_k%0d", fr_cnt), 32'(tm_byte), 32'(e[7:0]));
               chk($sformatf("end_k%0d", fr_cnt), 32'(tm_end), 32'(e[8]));
            end
            held_byte = tm_byte; held_end = tm_end; inflight = 1'b1; acked = 1'b0;
            fr_cnt++;
         end
         if (exp_q.size() != 0) chk("busy_while_pending", 32'(busy), 32'd1);
         if (done) begin
            done_cnt++;
            chk("done_busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("frame_len", 32'(fr_cnt), 32'd12);
            fr_cnt = 0;
         end
         prev_latch = tm_latch;
      end
   end

   initial begin : stim
      logic [8:0] pin [12];
      int d0, lat_cnt;
      rst = 1'b0; update = 1'b0; digits = '0; dp = '0; bright = '0; disp_on = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      chk_reset();
      @(negedge clk); rst = 1'b1;

      // Hand-computed frames pin the model.
      pin = '{9'h140, 9'h0C0, 9'h006, 9'h05B, 9'h04F, 9'h066, 9'h06D, 9'h07D, 9'h007, 9'h07F, 9'h16F, 9'h18F};
      for (int k = 0; k < 12; k++)
         chk($sformatf("pin_basic_k%0d", k), 32'(model_byte(k, 36'h987654321, 9'h000, 3'd7, 1'b1)), 32'(pin[k]));
      if (BLANK_EN) pin = '{9'h140, 9'h0C0, 9'h000, 9'h000, 9'h000, 9'h077, 9'h07C, 9'h039, 9'h05E, 9'h079, 9'h1F1, 9'h180};
      else          pin = '{9'h140, 9'h0C0, 9'h03F, 9'h03F, 9'h03F, 9'h077, 9'h07C, 9'h039, 9'h05E, 9'h079, 9'h1F1, 9'h180};
      for (int k = 0; k < 12; k++)
         chk($sformatf("pin_hex_k%0d", k), 32'(model_byte(k, 36'hFEDCBA000, 9'h100, 3'd0, 1'b0)), 32'(pin[k]));
      chk("pin_blank_d0", 32'(model_byte(2, 36'h000000050, 9'h000, 3'd3, 1'b1)), BLANK_EN ? 32'h000 : 32'h03F);
      chk("pin_blank_d1", 32'(model_byte(3, 36'h000000050, 9'h000, 3'd3, 1'b1)), 32'h06D);
      chk("pin_blank_d2", 32'(model_byte(4, 36'h000000050, 9'h000, 3'd3, 1'b1)), 32'h03F);

      // Basic frame with latency checks.
      digits = 36'h987654321; dp = 9'h000; bright = 3'd7; disp_on = 1'b1;
      d0 = done_cnt;
      start_frame(1'b1);
      wait_idle();
      chk("basic_done_count", 32'(done_cnt - d0), 32'd1);

      // Hex digits, decimal point, display off.
      digits = 36'hFEDCBA000; dp = 9'h100; bright = 3'd0; disp_on = 1'b0;
      start_frame(1'b0);
      wait_idle();

      // Leading-zero pattern.
      digits = 36'h000000050; dp = 9'h000; bright = 3'd3; disp_on = 1'b1;
      start_frame(1'b0);
      wait_idle();

      // Updates during transfer: one merged pending frame, sampled at FIN.
      digits = 36'h123456789; dp = 9'h001; bright = 3'd2; disp_on = 1'b1;
      d0 = done_cnt;
      start_frame(1'b0);
      wait_fr(4); pulse_update(); digits = 36'h111111111;
      wait_fr(6); pulse_update();
      wait_fr(7); pulse_update();
      digits = 36'h0ABCDEF00; dp = 9'h0AA; bright = 3'd5; disp_on = 1'b1;
      push_frame();
      wait_idle();
      chk("pending_done_count", 32'(done_cnt - d0), 32'd2);

      // Reset while byte 5 is latched.
      digits = 36'h246813579; dp = 9'h010; bright = 3'd4; disp_on = 1'b1;
      start_frame(1'b0);
      wait_fr(6);
      rst = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      chk_reset();
      @(negedge clk); rst = 1'b1;
      lat_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (tm_latch !== 1'b0) lat_cnt++;
      end
      chk("no_latch_after_reset", 32'(lat_cnt), 32'd0);
      wait_idle();
      d0 = done_cnt;
      start_frame(1'b1);
      wait_idle();
      chk("restart_done_count", 32'(done_cnt - d0), 32'd1);

      // Slow acknowledge.
      ack_delay = 10; busy_len = 3;
      digits = 36'h555000999; dp = 9'h044; bright = 3'd6; disp_on = 1'b1;
      d0 = done_cnt;
      start_frame(1'b0);
      wait_idle();
      chk("slow_done_count", 32'(done_cnt - d0), 32'd1);
      ack_delay = 0; busy_len = 5;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
